lsrx_follow: RTL

Clock-follower receiver for the local synchronous link. It sits at the far end of a link driven by an `lstx`-style transmitter and does not generate its own bit clock. It recovers bit timing from the transmitter's `uclk`, shifts in LSB-first words of DMSB+1 bits, and queues them in a 4-entry FIFO that a host drains with a toggle handshake. A programmable idle timeout re-aligns word framing after a truncated transfer.

---
 rtl/lsrx_follow_if.sv | 28 ++
 rtl/lsrx_follow.sv | 116 +++++++++++
 2 files changed

// File: rtl/lsrx_follow_if.sv
// rtl/lsrx_follow_if.sv - link and host-side signal bundle for the clock-follower receiver
interface lsrx_follow_if #(
  parameter int DMSB = 9,
  parameter int TMSB = 7
);
  logic                 uclk_in;
  logic                 rx;
  logic [TMSB:0]        tmo;
  logic                 pop;
  logic                 clear;
  logic signed [DMSB:0] rdata;
  logic                 empty;
  logic                 full;
  logic [2:0]           level;
  logic                 ovf;
  logic                 frerr;
  logic                 busy;

  modport master (
    output uclk_in, rx, tmo, pop, clear,
    input  rdata, empty, full, level, ovf, frerr, busy
  );

  modport slave (
    input  uclk_in, rx, tmo, pop, clear,
    output rdata, empty, full, level, ovf, frerr, busy
  );
endinterface

// File: rtl/lsrx_follow.sv
// rtl/lsrx_follow.sv - clock-follower link receiver with 4-entry FIFO and idle-timeout resync
module lsrx_follow #(
  parameter int DMSB = 9,
  parameter int BMSB = 3,
  parameter int TMSB = 7
) (
  input logic           clk,
  input logic           rstn,
  input logic           setn,
  lsrx_follow_if.slave  bus
);
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  localparam logic [BMSB:0] LP_BLAST = (BMSB+1)'(DMSB);

  // [0],[1] synchronize, [2] is the history flop for edge detection
  logic [2:0]    r_uclk_s, r_rx_s, r_pop_s, r_clr_s;
  logic [DMSB:1] r_sr;
  logic [DMSB:0] r_mem [4];
  logic [1:0]    r_wp, r_rp;
  logic [2:0]    r_cnt;
  logic [BMSB:0] r_bcnt;
  logic [TMSB:0] r_icnt;
  logic          r_ovf, r_frerr;
  state_t        r_state;

  logic          w_uev, w_pev, w_cev, w_bit;
  logic          w_wr, w_wr_ok, w_pop_ok, w_tout;
  logic [DMSB:0] w_word;
  logic          w_unused_rx_hist;

  assign w_uev            = r_uclk_s[1] ^ r_uclk_s[2];
  assign w_pev            = r_pop_s[1] ^ r_pop_s[2];
  assign w_cev            = r_clr_s[1] ^ r_clr_s[2];
  assign w_bit            = r_rx_s[1];
  assign w_unused_rx_hist = r_rx_s[2];

  always_comb begin
    w_word   = {w_bit, r_sr[DMSB:1]};
    w_wr     = w_uev && (r_bcnt == LP_BLAST);
    w_pop_ok = w_pev && (r_cnt != 3'd0);
    // a same-edge pop frees the slot, so a write at full still lands
    w_wr_ok  = w_wr && ((r_cnt != 3'd4) || w_pop_ok);
    w_tout   = !w_uev && (r_state == ST_SHIFT) && (bus.tmo != '0) && (r_icnt == bus.tmo);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_uclk_s <= '0;
      r_rx_s   <= '0;
      r_pop_s  <= '0;
      r_clr_s  <= '0;
      r_sr     <= '0;
      for (int i = 0; i < 4; i++) r_mem[i] <= '0;
      r_wp     <= '0;
      r_rp     <= '0;
      r_cnt    <= '0;
      r_bcnt   <= '0;
      r_icnt   <= '0;
      r_ovf    <= 1'b0;
      r_frerr  <= 1'b0;
      r_state  <= ST_IDLE;
    end else if (setn) begin
      r_uclk_s <= {r_uclk_s[1:0], bus.uclk_in};
      r_rx_s   <= {r_rx_s[1:0], bus.rx};
      r_pop_s  <= {r_pop_s[1:0], bus.pop};
      r_clr_s  <= {r_clr_s[1:0], bus.clear};
      if (w_cev) begin
        r_wp    <= '0;
        r_rp    <= '0;
        r_cnt   <= '0;
        r_bcnt  <= '0;
        r_icnt  <= '0;
        r_sr    <= '0;
        r_ovf   <= 1'b0;
        r_frerr <= 1'b0;
        r_state <= ST_IDLE;
      end else begin
        if (w_wr_ok) begin
          r_mem[r_wp] <= w_word;
          r_wp        <= r_wp + 2'd1;
        end
        if (w_wr && !w_wr_ok) r_ovf <= 1'b1;
        if (w_pop_ok) r_rp <= r_rp + 2'd1;
        r_cnt <= r_cnt + 3'(w_wr_ok) - 3'(w_pop_ok);
        if (w_uev) begin
          r_icnt <= '0;
          r_sr   <= w_word[DMSB:1];
          if (w_wr) begin
            r_bcnt  <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_bcnt  <= r_bcnt + (BMSB+1)'(1);
            r_state <= ST_SHIFT;
          end
        end else if (w_tout) begin
          r_bcnt  <= '0;
          r_sr    <= '0;
          r_icnt  <= '0;
          r_frerr <= 1'b1;
          r_state <= ST_IDLE;
        end else if ((r_state == ST_SHIFT) && !(&r_icnt)) begin
          r_icnt <= r_icnt + (TMSB+1)'(1);
        end
      end
    end
  end

  assign bus.rdata = r_mem[r_rp];
  assign bus.empty = (r_cnt == 3'd0);
  assign bus.full  = (r_cnt == 3'd4);
  assign bus.level = r_cnt;
  assign bus.ovf   = r_ovf;
  assign bus.frerr = r_frerr;
  assign bus.busy  = (r_state == ST_SHIFT);
endmodule
